// File: rtl/edge_pkg.sv
// edge_pkg: shared definitions for the edge-detector frame sequencer.
//   seq_state_e  : sequencer FSM states
//   stage_idx_t  : default-width stage index (STG_BITS_DEF bits)
//   BUF_AT_START : frame buffer read by stage 0 of every frame
package edge_pkg;

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, FINISH} seq_state_e;

   localparam int STG_BITS_DEF = 4;

   typedef logic [STG_BITS_DEF-1:0] stage_idx_t;

   localparam logic BUF_AT_START = 1'b0;

endpackage

// File: rtl/seq_wdog.sv
// seq_wdog: run-cycle watchdog for one sequencer stage.
// Built only when SEQ_WDOG_EN is defined.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the counter (stage CLEAR cycle)
//   enable     : count this cycle (stage RUN cycle)
//   expired    : high in the LIMIT-th consecutive enabled cycle
module seq_wdog #(
   parameter int LIMIT = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   // The counter stops at LIMIT so it can never wrap and miss a second expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && count != CW'(LIMIT))
         count <= count + CW'(1);
   end

   // count holds the number of run cycles already completed, so the
   // LIMIT-th run cycle is the one where it reads LIMIT-1.
   assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/edge_stage_seq.sv
// edge_stage_seq: frame-level sequencer for the edge-detector datapath.
// Runs NUM_STAGES pixel kernels one after another over two ping-pong frame
// buffers: per stage it pulses that stage's counter clear for one cycle,
// holds run until the stage reports done, then swaps the buffers.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : 1-cycle frame request, ignored while busy
//   abort       : drop the current frame, back to idle without frame_done
//   busy        : frame in progress
//   frame_done  : 1-cycle pulse after the last stage finishes
//   cur_stage   : index of the stage being cleared or run
//   stg_clr_n   : per-stage active-low counter clear
//   stg_run     : per-stage run enable, one-hot or zero
//   stg_done    : per-stage done, high on that stage's final-pixel cycle
//   src_sel     : frame buffer read by the active stage
//   dst_sel     : frame buffer written by the active stage (~src_sel)
//   err_wdog    : sticky watchdog error, cleared by the next accepted start
// Optional feature: define SEQ_WDOG_EN to build the per-stage run watchdog;
// without it err_wdog is tied low and a stage may run indefinitely.
module edge_stage_seq
   import edge_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int STG_BITS   = STG_BITS_DEF,
   parameter int IMG_WD     = 640,
   parameter int IMG_HT     = 480,
   parameter int WDOG_CYC   = IMG_WD * IMG_HT + 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   output logic                  busy,
   output logic                  frame_done,
   output logic [STG_BITS-1:0]   cur_stage,
   output logic [NUM_STAGES-1:0] stg_clr_n,
   output logic [NUM_STAGES-1:0] stg_run,
   input  logic [NUM_STAGES-1:0] stg_done,
   output logic                  src_sel,
   output logic                  dst_sel,
   output logic                  err_wdog
);

   localparam logic [NUM_STAGES-1:0] FIRST_CLR_N = ~NUM_STAGES'(1);
   localparam logic [STG_BITS-1:0]   LAST_STAGE  = STG_BITS'(NUM_STAGES - 1);

   if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_num_stages
      $error("edge_stage_seq: NUM_STAGES must be 1..16");
   end
   if ((1 << STG_BITS) < NUM_STAGES) begin : g_bad_stg_bits
      $error("edge_stage_seq: STG_BITS too narrow for NUM_STAGES");
   end
   if (WDOG_CYC < 1) begin : g_bad_wdog_cyc
      $error("edge_stage_seq: WDOG_CYC must be positive");
   end

   seq_state_e state;
   logic       done_sel;
   logic       wdog_expired;

   // stg_run is one-hot on the active stage during RUN, so masking with it
   // picks that stage's done and ignores the others without an index.
   assign done_sel = |(stg_done & stg_run);

`ifdef SEQ_WDOG_EN
   seq_wdog #(
      .LIMIT (WDOG_CYC)
   ) u_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state == CLEAR),
      .enable  (state == RUN),
      .expired (wdog_expired)
   );

   // Error flag is set on the cycle the watchdog forces the FSM home and
   // survives until the host accepts a fresh frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_wdog <= 1'b0;
      else if (state == IDLE && start && !abort)
         err_wdog <= 1'b0;
      else if (state == RUN && !abort && !done_sel && wdog_expired)
         err_wdog <= 1'b1;
   end
`else
   assign wdog_expired = 1'b0;
   assign err_wdog     = 1'b0;
`endif

   // Sequencer FSM with all outputs registered. Abort outranks everything
   // except reset; a stage's done outranks a simultaneous watchdog expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         cur_stage  <= '0;
         stg_clr_n  <= '1;
         stg_run    <= '0;
         src_sel    <= BUF_AT_START;
         dst_sel    <= ~BUF_AT_START;
      end else if (abort && state != IDLE) begin
         state      <= IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         cur_stage  <= '0;
         stg_clr_n  <= '1;
         stg_run    <= '0;
         src_sel    <= BUF_AT_START;
         dst_sel    <= ~BUF_AT_START;
      end else begin
         case (state)
            IDLE: begin
               frame_done <= 1'b0;
               if (start && !abort) begin
                  state     <= CLEAR;
                  busy      <= 1'b1;
                  cur_stage <= '0;
                  stg_clr_n <= FIRST_CLR_N;
                  src_sel   <= BUF_AT_START;
                  dst_sel   <= ~BUF_AT_START;
               end
            end
            CLEAR: begin
               state     <= RUN;
               stg_run   <= ~stg_clr_n;
               stg_clr_n <= '1;
            end
            RUN: begin
               if (done_sel) begin
                  stg_run <= '0;
                  if (cur_stage != LAST_STAGE) begin
                     state     <= CLEAR;
                     cur_stage <= cur_stage + STG_BITS'(1);
                     stg_clr_n <= ~(stg_run << 1);
                     src_sel   <= ~src_sel;
                     dst_sel   <= src_sel;
                  end else begin
                     state      <= FINISH;
                     frame_done <= 1'b1;
                  end
               end else if (wdog_expired) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  cur_stage <= '0;
                  stg_run   <= '0;
                  src_sel   <= BUF_AT_START;
                  dst_sel   <= ~BUF_AT_START;
               end
            end
            FINISH: begin
               state      <= IDLE;
               busy       <= 1'b0;
               frame_done <= 1'b0;
               cur_stage  <= '0;
               src_sel    <= BUF_AT_START;
               dst_sel    <= ~BUF_AT_START;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
